// File: rtl/vec_sum_sched.sv
// vec_sum_sched: round-robin job scheduler sharing one pipelined adder tree, accumulating one wide sum per job
module vec_sum_int #(
    parameter int bit_width = 16,
    parameter int length = 32,
    localparam int sum_width = bit_width + $clog2(length)
) (
    input  logic                        i_clk,
    input  logic signed [bit_width-1:0] i_vec [length],
    output logic signed [sum_width-1:0] o_sum
);
    logic signed [sum_width-1:0] node [length-1];
    logic signed [sum_width-1:0] tree [2*length-1];
    // heap layout: tree[0..length-2] are registered adders, the rest are the sign-extended leaves
    always_comb begin
        for (int i = 0; i < length - 1; i++) tree[i] = node[i];
        for (int j = 0; j < length; j++) tree[length-1+j] = sum_width'(i_vec[j]);
    end
    always_ff @(posedge i_clk)
        for (int i = 0; i < length - 1; i++) node[i] <= tree[2*i+1] + tree[2*i+2];
    assign o_sum = tree[0];
endmodule

module vec_sum_sched #(
    parameter int bit_width = 16,
    parameter int length = 32,
    parameter int num_req = 4,
    parameter int max_beats = 256,
    localparam int tree_depth = $clog2(length),
    localparam int acc_width = bit_width + $clog2(length) + $clog2(max_beats),
    localparam int id_width = $clog2(num_req)
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [num_req-1:0]          i_req_valid,
    input  logic [num_req-1:0]          i_req_last,
    input  logic signed [bit_width-1:0] i_req_vec [num_req][length],
    output logic [num_req-1:0]          o_req_ready,
    output logic                        o_valid,
    output logic signed [acc_width-1:0] o_sum,
    output logic [id_width-1:0]         o_id,
    output logic                        o_busy
);
    localparam int sum_width = bit_width + tree_depth;
    typedef enum logic {IDLE, LOCKED} state_t;
    state_t state;
    logic [id_width-1:0] owner, rr_ptr, gnt, sel;
    logic found, take, take_last;
    logic signed [bit_width-1:0] tree_in [length];
    logic signed [sum_width-1:0] tree_sum;
    logic [tree_depth-1:0] tag_valid, tag_first, tag_last;
    logic [id_width-1:0] tag_id [tree_depth];
    logic signed [acc_width-1:0] acc, acc_next;
    // scanning downward lets the lowest offset from rr_ptr overwrite the others
    always_comb begin
        found = 1'b0;
        gnt = '0;
        for (int k = num_req - 1; k >= 0; k--)
            if (i_req_valid[id_width'((int'(rr_ptr) + k) % num_req)]) begin
                found = 1'b1;
                gnt = id_width'((int'(rr_ptr) + k) % num_req);
            end
    end
    assign sel = state == LOCKED ? owner : gnt;
    assign take = !i_rst && (state == LOCKED ? i_req_valid[owner] : found);
    assign take_last = i_req_last[sel];
    assign o_req_ready = take ? num_req'(1) << sel : '0;
    always_comb
        for (int j = 0; j < length; j++) tree_in[j] = take ? i_req_vec[sel][j] : '0;
    vec_sum_int #(.bit_width(bit_width), .length(length)) u_tree (
        .i_clk(i_clk),
        .i_vec(tree_in),
        .o_sum(tree_sum)
    );
    assign acc_next = tag_first[tree_depth-1] ? acc_width'(tree_sum) : acc + acc_width'(tree_sum);
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
            owner <= '0;
            rr_ptr <= '0;
            tag_valid <= '0;
            tag_first <= '0;
            tag_last <= '0;
            for (int i = 0; i < tree_depth; i++) tag_id[i] <= '0;
            acc <= '0;
            o_valid <= 1'b0;
            o_sum <= '0;
            o_id <= '0;
            o_busy <= 1'b0;
        end else begin
            if (take && take_last) begin
                state <= IDLE;
                rr_ptr <= id_width'((int'(sel) + 1) % num_req);
            end else if (take && state == IDLE) begin
                state <= LOCKED;
                owner <= gnt;
            end
            tag_valid[0] <= take;
            tag_first[0] <= state == IDLE;
            tag_last[0] <= take_last;
            tag_id[0] <= sel;
            for (int i = 1; i < tree_depth; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_first[i] <= tag_first[i-1];
                tag_last[i] <= tag_last[i-1];
                tag_id[i] <= tag_id[i-1];
            end
            if (tag_valid[tree_depth-1]) begin
                acc <= acc_next;
                o_valid <= tag_last[tree_depth-1];
                if (tag_last[tree_depth-1]) begin
                    o_sum <= acc_next;
                    o_id <= tag_id[tree_depth-1];
                end
            end else begin
                o_valid <= 1'b0;
            end
            o_busy <= state == LOCKED || take || |tag_valid;
        end
    end
endmodule

// File: doc/vec_sum_sched.md
# vec_sum_sched

Job-level scheduler that shares one pipelined integer adder tree (`vec_sum_int`, instantiated internally) between `num_req` requesters. Each requester streams a job of one or more `length`-element beats, terminated by a `last` flag. The block arbitrates round-robin at job granularity and tracks every beat through the tree's fixed latency with a tag pipeline. It accumulates all beat sums of a job and emits one wide sum tagged with the requester ID. It sits between the vector producers (dot-product and reduction front ends) and the consumers of reduced scalars.

## Interface
- `bit_width`, 16: element width, signed.
- `length`, 32: elements per beat; power of two, ≥2.
- `num_req`, 4: number of requesters, ≥2.
- `max_beats`, 256: maximum beats per job; the accumulator is sized for this.
- `tree_depth`, `$clog2(length)`: adder tree latency in cycles.
- `acc_width`, `bit_width+$clog2(length)+$clog2(max_beats)`: width of the job sum.
- `id_width`, `$clog2(num_req)`: width of the requester ID.
- `i_clk`  in  1  clock; the single clock for the block.
- `i_rst`  in  1  reset, synchronous, active-high.
- `i_req_valid`  in  [num_req]  beat valid, one bit per requester.
- `i_req_last`  in  [num_req]  beat is the final beat of its job.
- `i_req_vec`  in  signed [bit_width-1:0] [num_req][length]  beat data per requester.
- `o_req_ready`  out  [num_req]  beat accepted when ready and valid are both high; at most one bit set per cycle.
- `o_valid`  out  1  single-cycle pulse marking a completed job sum.
- `o_sum`  out  signed [acc_width-1:0]  job sum; held until the next `o_valid`.
- `o_id`  out  [id_width-1:0]  requester that owned the job; held with `o_sum`.
- `o_busy`  out  1  high when the FSM is LOCKED or any tag-pipeline stage is valid.

## Operation
- FSM states: IDLE, LOCKED. Registers: `owner`, `rr_ptr`.
- IDLE:
  - Grant the first requester with valid high, searching from `rr_ptr` upward with wrap-around.
  - `o_req_ready[g]` is asserted combinationally in the same cycle, so the first beat is accepted immediately.
  - If the accepted beat has `last` set: stay in IDLE, `rr_ptr <= g+1` (mod `num_req`).
  - Otherwise: go to LOCKED with `owner <= g`.
- LOCKED:
  - Only `o_req_ready[owner]` may be high; it follows `i_req_valid[owner]`.
  - If the owner drops valid, a bubble results: nothing is accepted and nothing is pushed into the tree.
  - An accepted beat with `last` set returns the FSM to IDLE with `rr_ptr <= owner+1`.
  - Other requesters are never granted until that last beat is accepted.
- Tree input:
  - The tree input is the accepted requester's vector.
  - When no beat is accepted, the tree input is driven to zero.
- Tag pipeline:
  - `tree_depth` stages carrying {valid, first, last, id}, shifted every cycle in lockstep with the tree.
  - `first` is high on the first beat accepted after a job start.
- Accumulator (one register stage after the tree output):
  - Tag valid with first: `acc <= sext(tree_sum)`.
  - Tag valid without first: `acc <= acc + sext(tree_sum)`.
  - Tag valid with last: `o_sum <= next acc value`, `o_id <= tag id`, `o_valid <= 1`.
  - Tag invalid: accumulator holds and `o_valid <= 0`.
  - A beat carrying both first and last is a single-beat job: `o_sum = sext(tree_sum)`.
- Arithmetic: two's complement, sign-extended. A job of more than `max_beats` beats wraps modulo 2^`acc_width` and is not flagged.
- The tree has no reset. Its data is don't-care wherever the matching tag is invalid.

## Timing
- Reset values: FSM IDLE, `rr_ptr=0`, `owner=0`, all tag valids 0, `acc=0`, `o_valid=0`, `o_sum=0`, `o_id=0`, `o_busy=0`. `o_req_ready` is 0 while `i_rst` is high.
- Latency: last beat accepted at cycle t gives `o_valid` high in cycle t+`tree_depth`+1. With `length`=32 this is t+6.
- Throughput: one beat per cycle, including back-to-back jobs from different requesters.
- Overlapping jobs: job B's first beat may follow job A's last beat in the very next cycle. The first-tag reload keeps the two sums separate.
- Output: `o_valid` never stalls; there is no output backpressure. Consumers must sample it on the pulse.
- Reset mid-job: all in-flight beats are discarded. No `o_valid` is produced until a new job's last beat has traversed the pipeline.
- Same-cycle requests in IDLE: the lowest index at or after `rr_ptr` wins.

## Test plan
- Single job: req0 sends 1 beat of all +1 with last set, accepted at t -> `o_valid` at t+6, `o_sum=32`, `o_id=0`; `o_busy` high from t+1 through t+6.
- Multi-beat job: req2 sends 3 beats of all 1, all 2, all -1 -> `o_sum=64`, `o_id=2`, a single pulse.
- Round-robin: all four requesters hold 1-beat jobs from reset -> grants 0,1,2,3 on consecutive cycles, then 0 again; outputs in ID order with values 32,64,96,128 (req k data all k+1).
- Locking: req1 sends a 3-beat job with a 2-cycle valid gap while req3 stays valid -> req3 is not ready until after req1's last beat is accepted; sums are correct and unmixed.
- Extremes: a 256-beat job of all -32768 -> `o_sum = -2^28` exactly, no wrap.
- Reset after beat 2 of a 4-beat job -> no `o_valid`; a subsequent 1-beat job of all 1 from req0 gives `o_sum=32`.
